// File: rtl/program_loader.sv
// Byte-serial program loader: receives a little-endian word count followed by
// that many little-endian 32-bit words and writes them into an instruction RAM.
module program_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       di,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       nwords
);

  typedef enum logic [2:0] {IDLE, LEN, DATA, DONE, ERR} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        byte_cnt_reg;
  logic [ADDR_W-1:0] word_addr_reg;
  logic [31:0]       asm_reg;
  logic              pending_reg;

  logic              idle_like;
  logic              start_ok;
  logic              last_byte;
  logic              last_word;
  logic [31:0]       len_full;

  assign idle_like = (state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERR);
  assign start_ok  = start && !busy && idle_like;
  assign last_byte = (byte_cnt_reg == 2'd3);
  assign len_full  = {rx_data, nwords[23:0]};
  // The final write pulse is the one issued while the current address is N-1.
  assign last_word = pending_reg && (32'(word_addr_reg) == nwords - 32'd1);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE, ERR: begin
        if (start_ok) state_next = LEN;
      end
      LEN: begin
        if (rx_valid && last_byte) begin
          if (len_full == 32'd0)             state_next = DONE;
          else if (len_full > 32'(DEPTH))    state_next = ERR;
          else                               state_next = DATA;
        end
      end
      DATA: begin
        if (last_word) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we            <= 1'b0;
      waddr         <= '0;
      di            <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      nwords        <= '0;
      byte_cnt_reg  <= '0;
      word_addr_reg <= '0;
      asm_reg       <= '0;
      pending_reg   <= 1'b0;
    end else begin
      we          <= 1'b0;
      pending_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE, ERR: begin
          if (start_ok) begin
            busy          <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
            nwords        <= '0;
            byte_cnt_reg  <= '0;
            word_addr_reg <= '0;
          end else if (state_reg == DONE) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else if (state_reg == ERR) begin
            busy <= 1'b0;
            err  <= 1'b1;
          end
        end
        LEN: begin
          if (rx_valid) begin
            nwords[{byte_cnt_reg, 3'b000} +: 8] <= rx_data;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (last_byte) word_addr_reg <= '0;
          end
        end
        DATA: begin
          if (rx_valid) begin
            asm_reg[{byte_cnt_reg, 3'b000} +: 8] <= rx_data;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (last_byte) pending_reg <= 1'b1;
          end
          // Write is issued one cycle after word completion; a new byte may land concurrently.
          if (pending_reg) begin
            we            <= 1'b1;
            waddr         <= word_addr_reg;
            di            <= asm_reg;
            word_addr_reg <= word_addr_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, the write-address width.
REQ-002 SHALL have parameter DEPTH, default 1024, the maximum word count; DEPTH <= 2**ADDR_W.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a single-cycle load request.
REQ-006 SHALL have port rx_valid, input, 1, which qualifies rx_data for exactly one cycle per byte.
REQ-007 SHALL have port rx_data, input, 8, the incoming byte stream.
REQ-008 SHALL have port we, output, 1, the instruction-RAM write enable.
REQ-009 SHALL have port waddr, output, ADDR_W, the instruction-RAM word address.
REQ-010 SHALL have port di, output, 32, the instruction-RAM write data.
REQ-011 SHALL have port busy, output, 1, high while a load is in progress.
REQ-012 SHALL have port done, output, 1, high once a load completes successfully.
REQ-013 SHALL have port err, output, 1, high when a header is rejected.
REQ-014 SHALL have port nwords, output, 32, the most recent received word count.

Function
REQ-015 SHALL implement states IDLE, LEN, DATA, DONE, ERR; all outputs SHALL be registered.
REQ-016 SHALL stream-format input as a 4-byte little-endian word count N, then N words of 4 bytes each, little-endian.
REQ-017 SHALL, on start in IDLE, DONE or ERR: enter LEN next cycle; set busy=1, done=0, err=0; clear the byte counter and the length register.
REQ-018 SHALL ignore start while busy=1.
REQ-019 SHALL ignore rx_valid in IDLE, DONE and ERR.
REQ-020 SHALL, in LEN, place accepted byte k (0..3) into nwords bits [8k+7:8k].
REQ-021 SHALL, on the 4th LEN byte: if N==0, go to DONE; else if N>DEPTH, go to ERR; else go to DATA with word address 0.
REQ-022 SHALL, in DATA, place accepted byte k into the assembly register bits [8k+7:8k]; the byte counter wraps 3->0.
REQ-023 SHALL, in the cycle after the 4th byte of a word is accepted, assert we for exactly one cycle with di = assembled word and waddr = current word address.
REQ-024 SHALL increment the word address by 1 after each write pulse.
REQ-025 SHALL hold we=0 at all other times; di and waddr hold their last values when we=0.
REQ-026 SHALL accept an rx_valid byte in the same cycle as a we pulse without loss; there is no backpressure.
REQ-027 SHALL, on the cycle of the final (Nth) write pulse, go to DONE; busy=0 and done=1 from the next cycle.
REQ-028 SHALL, in ERR, set busy=0 and err=1, held until start or rst.
REQ-029 SHALL, in DONE, hold done=1 and nwords=N until start or rst.
REQ-030 SHALL keep done and err mutually exclusive.
REQ-031 SHALL, for N==DEPTH, write addresses 0..DEPTH-1 with no address wrap; address DEPTH-1 is the last write.

Reset
REQ-032 SHALL, with rst=1 at a clock edge: state=IDLE; we=0, waddr=0, di=0, busy=0, done=0, err=0, nwords=0; counters cleared.
REQ-033 SHALL, on rst mid-load, abort the load with no further write pulse, including one pending from a just-completed word.
REQ-034 SHALL give rst priority over start and rx_valid in the same cycle.

Verification
REQ-035 Header 02 00 00 00, words 0x13 and 0x00000093 (bytes 13 00 00 00 93 00 00 00) -> we pulses at waddr 0 di 0x00000013, then waddr 1 di 0x00000093; done=1, nwords=2.
REQ-036 Header 00 00 00 00 -> no we pulse; done=1 the cycle after the 4th byte is accepted, nwords=0.
REQ-037 Header 01 04 00 00 (N=1025) -> err=1, done=0, no we pulse; a subsequent start followed by a valid stream -> loads normally, err=0.
REQ-038 Back-to-back rx_valid every cycle for N=3 -> exactly 3 single-cycle we pulses, 4 cycles apart, no byte lost.
REQ-039 rst asserted the cycle after the 4th byte of word 5 -> no we pulse; all outputs at reset values next cycle.
REQ-040 N=1024 with a pattern word = address -> last pulse waddr=1023 di=0x000003FF; done=1.
